// File: rtl/ir_emitter_driver.sv
// ============================================================================
// Module   : ir_emitter_driver
// Purpose  : Drives the IR emitter LED with a fixed on/off duty pattern and
//            issues settled sample strobes for the reflected-light sensor.
//            Optional macro IR_AMBIENT_SAMPLE_EN adds a dark-phase strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_emitter_driver #(
    parameter logic [15:0] ON_CYCLES     = 16'd50,
    parameter logic [15:0] OFF_CYCLES    = 16'd150,
    parameter logic [15:0] SETTLE_CYCLES = 16'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       ledOut,
    output logic       sampleStrobe,
    output logic       ambientStrobe,
    output logic       busy,
    output logic [7:0] periodCount
);

    localparam logic [15:0] c_onLast     = ON_CYCLES - 16'd1;
    localparam logic [15:0] c_offLast    = OFF_CYCLES - 16'd1;
    localparam logic [15:0] c_settleLast = SETTLE_CYCLES - 16'd1;

    generate
        if (ON_CYCLES < 16'd2) begin : g_badOnCycles
            $error("ir_emitter_driver: ON_CYCLES must be at least 2");
        end
        if (OFF_CYCLES < 16'd2) begin : g_badOffCycles
            $error("ir_emitter_driver: OFF_CYCLES must be at least 2");
        end
        if ((SETTLE_CYCLES < 16'd1) || (SETTLE_CYCLES >= ON_CYCLES) ||
            (SETTLE_CYCLES >= OFF_CYCLES)) begin : g_badSettleCycles
            $error("ir_emitter_driver: SETTLE_CYCLES must be >= 1 and below both phase lengths");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;

    // Strobes are decoded one count early so the registered pulse lines up
    // with the cycle in which the phase counter equals SETTLE_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            ledOut        <= 1'b0;
            sampleStrobe  <= 1'b0;
            busy          <= 1'b0;
            periodCount   <= 8'd0;
`ifdef IR_AMBIENT_SAMPLE_EN
            ambientStrobe <= 1'b0;
`endif
        end else begin
            sampleStrobe  <= (r_state == S_ON) && (r_cnt == c_settleLast);
`ifdef IR_AMBIENT_SAMPLE_EN
            ambientStrobe <= (r_state == S_OFF) && (r_cnt == c_settleLast);
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 16'd0;
                    if (enable) begin
                        r_state     <= S_ON;
                        ledOut      <= 1'b1;
                        busy        <= 1'b1;
                        periodCount <= 8'd0;
                    end
                end
                S_ON: begin
                    if (r_cnt == c_onLast) begin
                        r_state <= S_OFF;
                        r_cnt   <= 16'd0;
                        ledOut  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_OFF: begin
                    if (r_cnt == c_offLast) begin
                        r_cnt       <= 16'd0;
                        periodCount <= periodCount + 8'd1;
                        if (enable) begin
                            r_state <= S_ON;
                            ledOut  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                    ledOut  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef IR_AMBIENT_SAMPLE_EN
    assign ambientStrobe = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ir_emitter_driver.sv
// ============================================================================
// Module   : tb_ir_emitter_driver
// Purpose  : Self-checking bench for ir_emitter_driver (ON=5, OFF=7, SETTLE=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_emitter_driver;

    localparam int PER = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ledOut, sampleStrobe, ambientStrobe, busy;
    logic [7:0] periodCount;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    ir_emitter_driver #(
        .ON_CYCLES    (16'd5),
        .OFF_CYCLES   (16'd7),
        .SETTLE_CYCLES(16'd2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ledOut       (ledOut),
        .sampleStrobe (sampleStrobe),
        .ambientStrobe(ambientStrobe),
        .busy         (busy),
        .periodCount  (periodCount)
    );

    typedef struct {
        logic        en;
        logic [11:0] exp;   // {led, sample, ambient, busy, periodCount}
    } vec_t;

    vec_t tbl[36];

    // Expected outputs k edges after the starting edge, enable held high.
    function automatic logic [11:0] runExp(int k);
        int         p;
        logic       amb;
        logic [7:0] pc;
        p  = k % PER;
        pc = 8'(k / PER);
`ifdef IR_AMBIENT_SAMPLE_EN
        amb = (p == 7);
`else
        amb = 1'b0;
`endif
        return {(p < 5), (p == 2), amb, 1'b1, pc};
    endfunction

    function automatic logic [11:0] outs();
        return {ledOut, sampleStrobe, ambientStrobe, busy, periodCount};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        reset  = 1'b0;
    endtask

    initial begin
        int ledHigh, strobes, errs;
        logic [7:0] pcLast;

        for (int k = 0; k < 36; k++) begin
            tbl[k].en  = 1'b1;
            tbl[k].exp = runExp(k);
        end

        // Reset state
        step();
        check("reset_state", 32'(outs()), 32'h000);
        reset = 1'b0;

        // Continuous operation, three periods
        for (int k = 0; k < 36; k++) begin
            enable = tbl[k].en;
            step();
            check($sformatf("run_k%0d", k), 32'(outs()), 32'(tbl[k].exp));
        end

        // Drop enable in the 2nd ON cycle: the period completes, then IDLE
        restart();
        enable = 1'b1;
        step();
        check("drop_k0", 32'(outs()), 32'(runExp(0)));
        enable = 1'b0;
        for (int k = 1; k < PER; k++) begin
            step();
            check($sformatf("drop_k%0d", k), 32'(outs()), 32'(runExp(k)));
        end
        step();
        check("drop_idle", 32'(outs()), 32'h001);
        step();
        check("drop_hold", 32'(outs()), 32'h001);

        // Asynchronous reset in the 3rd ON cycle of the second period
        restart();
        enable = 1'b1;
        for (int k = 0; k <= 14; k++) step();
        check("pre_reset", 32'(outs()), 32'(runExp(14)));
        reset = 1'b1;
        #1;
        check("async_reset", 32'(outs()), 32'h000);
        step();
        check("reset_held", 32'(outs()), 32'h000);
        reset = 1'b0;
        step();
        check("after_reset", 32'(outs()), 32'(runExp(0)));

        // 256 periods: periodCount wraps, LED duty exact
        restart();
        enable  = 1'b1;
        ledHigh = 0;
        errs    = 0;
        pcLast  = 8'd0;
        for (int k = 0; k <= 256 * PER; k++) begin
            step();
            if (outs() !== runExp(k)) errs++;
            if (k < 256 * PER && ledOut) ledHigh++;
            if (k == 256 * PER - 1) pcLast = periodCount;
        end
        check("wrap_cycle_errors", 32'(errs), 32'd0);
        check("wrap_led_cycles", 32'(ledHigh), 32'(256 * 5));
        check("wrap_pc_255", 32'(pcLast), 32'd255);
        check("wrap_pc_0", 32'(periodCount), 32'd0);

        // One-cycle enable pulse from IDLE: exactly one period
        restart();
        step();
        check("pulse_idle", 32'(outs()), 32'h000);
        enable  = 1'b1;
        step();
        enable  = 1'b0;
        ledHigh = int'(ledOut);
        strobes = int'(sampleStrobe);
        for (int k = 1; k < PER; k++) begin
            step();
            ledHigh += int'(ledOut);
            strobes += int'(sampleStrobe);
        end
        check("pulse_led_cycles", 32'(ledHigh), 32'd5);
        check("pulse_strobes", 32'(strobes), 32'd1);
        check("pulse_still_busy", 32'(busy), 32'd1);
        step();
        check("pulse_done", 32'(outs()), 32'h001);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    // Sample and ambient strobes never overlap
    always @(negedge clk) begin
        if (sampleStrobe && ambientStrobe) begin
            totalCnt++;
            $display("FAIL strobe_overlap: got 1 expected 0");
        end
    end

endmodule

`default_nettype wire
